camera_capture: RTL and testbench
=================================

CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter DATA_W, default 8, meaning width of one camera bus sample.
REQ-002 Parameter BYTES_PER_PIXEL, default 2, legal 1..4, meaning samples assembled into one pixel.
REQ-003 Parameter MSB_FIRST, default 1; 1 means the first sample of a pixel lands in the top slot, 0 means it lands in the bottom slot.
REQ-004 Parameter H_W, default 11, meaning width of the column counter.
REQ-005 Parameter V_W, default 10, meaning width of the row counter.
REQ-006 clk_pixel_in  input  1  system clock; the block has one clock and all logic is on its rising edge.
REQ-007 rst_in  input  1  reset, synchronous and active-high.
REQ-008 pclk_cam_in  input  1  camera pixel clock, sampled as data, not used as a clock.
REQ-009 hs_cam_in  input  1  camera line-valid, high during active samples.
REQ-010 vs_cam_in  input  1  camera frame-valid, high during active frame.
REQ-011 data_cam_in  input  DATA_W  camera sample.
REQ-012 pixel_out  output  DATA_W*BYTES_PER_PIXEL  assembled pixel.
REQ-013 valid_out  output  1  one-cycle strobe, pixel_out/hcount_out/vcount_out valid.
REQ-014 hcount_out  output  H_W  column of the current pixel.
REQ-015 vcount_out  output  V_W  row of the current pixel.
REQ-016 frame_start_out  output  1  one-cycle pulse, first valid pixel of a frame.
REQ-017 row_end_out  output  1  one-cycle pulse on each active-line end.
REQ-018 short_row_out  output  1  one-cycle pulse when a line ends with a partial pixel.

Function
REQ-019 Sample edge: pclk_prev is registered each cycle; a sample event is pclk_cam_in=1 and pclk_prev=0; all camera inputs are evaluated only on sample events.
REQ-020 Active sample: hs_cam_in=1 and vs_cam_in=1 at a sample event.
REQ-021 Slot counter: 0..BYTES_PER_PIXEL-1; each active sample writes the slot, then the counter increments; wrap to 0 on completion.
REQ-022 Slot placement, MSB_FIRST=1: slot k goes to bits [(BPP-k)*DATA_W-1 -: DATA_W].
REQ-023 Slot placement, MSB_FIRST=0: slot k goes to bits [(k+1)*DATA_W-1 -: DATA_W].
REQ-024 Pixel completion: when the final slot is written, valid_out=1 on the next clk_pixel_in cycle only (latency 1 cycle from the detecting edge); otherwise 0.
REQ-025 pixel_out holds its last value between strobes.
REQ-026 BYTES_PER_PIXEL=1: every active sample produces a strobe.
REQ-027 Line start: first active sample after a non-active sample event forces slot 0 regardless of counter (resync).
REQ-028 Column counter: hcount_out=0 for the first pixel of a line, +1 per strobe.
REQ-029 Column counter saturates at 2^H_W-1 and does not wrap.
REQ-030 Line end: sample event with previous active and current not active; row_end_out pulses the following cycle.
REQ-031 Line end with slot counter != 0: short_row_out pulses simultaneously with row_end_out, partial pixel discarded, no strobe.
REQ-032 Row counter: vcount_out increments after each line end (saturating at 2^V_W-1), and resets to 0 on a vs_cam_in falling sample event.
REQ-033 frame_start_out: coincident with valid_out for the first strobe after vs_cam_in rises (vcount 0, hcount 0).
REQ-034 Sample events with hs_cam_in=1 and vs_cam_in=0 are ignored entirely.
REQ-035 pclk_cam_in held constant: no events, outputs stable, strobes stay 0.

Reset
REQ-036 During rst_in=1: valid_out, frame_start_out, row_end_out, short_row_out, hcount_out, vcount_out, pixel_out, slot counter=0.
REQ-037 During rst_in=1: the previous-active flag clears and pclk_prev loads 1, so no spurious event occurs on the first post-reset cycle.
REQ-038 Reset mid-line discards any partial pixel; the next active sample is treated as a line start (slot 0).
REQ-039 After reset the frame state is "no frame seen"; frame_start_out fires on the first strobe after the first vs_cam_in rise.

Verification
REQ-040 DATA_W=8, BPP=2, MSB_FIRST=1; line samples 0xAB,0xCD,0x12,0x34 -> strobes 0xABCD (h=0, frame_start=1), then 0x1234 (h=1), each 1 cycle wide, then row_end_out.
REQ-041 Same samples with MSB_FIRST=0 -> 0xCDAB, then 0x3412.
REQ-042 BPP=3; line of 7 samples -> 2 strobes, then row_end_out and short_row_out in the same cycle; the next line starts at slot 0 with vcount_out=1.
REQ-043 Assert rst_in after 1 sample of a pixel; release; feed 0x11,0x22 -> strobe 0x1122 with hcount_out=0 and no short_row_out.
REQ-044 pclk_cam_in at 1/4 of clk_pixel_in, 640 pixels x 3 lines, then vs_cam_in falls -> 1920 strobes, hcount_out last=639, vcount_out 0..2, then 0 after vs fall.
REQ-045 H_W=2; line of 6 pixels -> hcount_out sequence 0,1,2,3,3,3.

Source files
------------

// File: rtl/camera_capture.sv
// Camera parallel-bus capture: oversamples the camera pixel clock in the system
// clock domain, packs bus samples into pixels and tracks column/row position.
module camera_capture #(
  parameter int DATA_W          = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int MSB_FIRST       = 1,
  parameter int H_W             = 11,
  parameter int V_W             = 10
) (
  input  logic                              clk_pixel_in,
  input  logic                              rst_in,
  input  logic                              pclk_cam_in,
  input  logic                              hs_cam_in,
  input  logic                              vs_cam_in,
  input  logic [DATA_W-1:0]                 data_cam_in,
  output logic [DATA_W*BYTES_PER_PIXEL-1:0] pixel_out,
  output logic                              valid_out,
  output logic [H_W-1:0]                    hcount_out,
  output logic [V_W-1:0]                    vcount_out,
  output logic                              frame_start_out,
  output logic                              row_end_out,
  output logic                              short_row_out
);
  localparam int PW     = DATA_W * BYTES_PER_PIXEL;
  localparam int SLOT_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BYTES_PER_PIXEL - 1);

  logic              pclk_prev, prev_active, vs_prev, frame_armed;
  logic [SLOT_W-1:0] slot_cnt, slot;
  logic [PW-1:0]     pix_buf, pix_next;
  logic [H_W-1:0]    col, col_use;
  logic              sample_evt, active, ignored, line_start, vs_rise, vs_fall;

  assign sample_evt = pclk_cam_in & ~pclk_prev;
  assign active     = hs_cam_in & vs_cam_in;
  assign ignored    = hs_cam_in & ~vs_cam_in;
  assign vs_rise    = sample_evt & vs_cam_in & ~vs_prev;
  assign vs_fall    = sample_evt & ~vs_cam_in & vs_prev;
  // A fresh line always restarts packing at slot 0, whatever the counter says.
  assign line_start = sample_evt & active & ~prev_active;
  assign slot       = line_start ? '0 : slot_cnt;
  assign col_use    = line_start ? '0 : col;

  always_comb begin
    pix_next = pix_buf;
    for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (slot == SLOT_W'(k))
        pix_next[((MSB_FIRST != 0) ? (BYTES_PER_PIXEL - 1 - k) : k) * DATA_W +: DATA_W] = data_cam_in;
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      pclk_prev       <= 1'b1;
      prev_active     <= 1'b0;
      vs_prev         <= 1'b0;
      frame_armed     <= 1'b0;
      slot_cnt        <= '0;
      pix_buf         <= '0;
      col             <= '0;
      pixel_out       <= '0;
      valid_out       <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_start_out <= 1'b0;
      row_end_out     <= 1'b0;
      short_row_out   <= 1'b0;
    end else begin
      pclk_prev       <= pclk_cam_in;
      valid_out       <= 1'b0;
      frame_start_out <= 1'b0;
      row_end_out     <= 1'b0;
      short_row_out   <= 1'b0;
      if (sample_evt) begin
        vs_prev <= vs_cam_in;
        if (vs_rise) frame_armed <= 1'b1;
        if (active) begin
          prev_active <= 1'b1;
          pix_buf     <= pix_next;
          if (line_start) col <= '0;
          if (slot == LAST_SLOT) begin
            slot_cnt        <= '0;
            pixel_out       <= pix_next;
            valid_out       <= 1'b1;
            hcount_out      <= col_use;
            col             <= (col_use == '1) ? col_use : col_use + 1'b1;
            frame_start_out <= frame_armed | vs_rise;
            frame_armed     <= 1'b0;
          end else begin
            slot_cnt <= slot + 1'b1;
          end
        end else if (!ignored) begin
          prev_active <= 1'b0;
          if (prev_active) begin
            row_end_out   <= 1'b1;
            short_row_out <= (slot_cnt != '0);
            slot_cnt      <= '0;
            vcount_out    <= (vcount_out == '1) ? vcount_out : vcount_out + 1'b1;
          end
        end
        // End of frame drops any line in progress and rewinds the row counter.
        if (vs_fall) begin
          vcount_out  <= '0;
          prev_active <= 1'b0;
          slot_cnt    <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture: four configurations share one camera bus
// and each scenario task checks its own expectations.
module tb_camera_capture;
  logic clk = 1'b0, rst = 1'b1, pclk = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [7:0] data = 8'h00;
  always #5 clk = ~clk;

  logic [15:0] p0, p1, p3;
  logic [23:0] p2;
  logic v0, v1, v2, v3, fs0, fs1, fs2, fs3, re0, re1, re2, re3, sr0, sr1, sr2, sr3;
  logic [10:0] h0, h1, h2;
  logic [1:0]  h3;
  logic [9:0]  vc0, vc1, vc2, vc3;

  camera_capture #(.DATA_W(8), .BYTES_PER_PIXEL(2), .MSB_FIRST(1)) d0 (
    .clk_pixel_in(clk), .rst_in(rst), .pclk_cam_in(pclk), .hs_cam_in(hs), .vs_cam_in(vs),
    .data_cam_in(data), .pixel_out(p0), .valid_out(v0), .hcount_out(h0), .vcount_out(vc0),
    .frame_start_out(fs0), .row_end_out(re0), .short_row_out(sr0));
  camera_capture #(.DATA_W(8), .BYTES_PER_PIXEL(2), .MSB_FIRST(0)) d1 (
    .clk_pixel_in(clk), .rst_in(rst), .pclk_cam_in(pclk), .hs_cam_in(hs), .vs_cam_in(vs),
    .data_cam_in(data), .pixel_out(p1), .valid_out(v1), .hcount_out(h1), .vcount_out(vc1),
    .frame_start_out(fs1), .row_end_out(re1), .short_row_out(sr1));
  camera_capture #(.DATA_W(8), .BYTES_PER_PIXEL(3), .MSB_FIRST(1)) d2 (
    .clk_pixel_in(clk), .rst_in(rst), .pclk_cam_in(pclk), .hs_cam_in(hs), .vs_cam_in(vs),
    .data_cam_in(data), .pixel_out(p2), .valid_out(v2), .hcount_out(h2), .vcount_out(vc2),
    .frame_start_out(fs2), .row_end_out(re2), .short_row_out(sr2));
  camera_capture #(.DATA_W(8), .BYTES_PER_PIXEL(2), .MSB_FIRST(1), .H_W(2)) d3 (
    .clk_pixel_in(clk), .rst_in(rst), .pclk_cam_in(pclk), .hs_cam_in(hs), .vs_cam_in(vs),
    .data_cam_in(data), .pixel_out(p3), .valid_out(v3), .hcount_out(h3), .vcount_out(vc3),
    .frame_start_out(fs3), .row_end_out(re3), .short_row_out(sr3));

  typedef struct { logic [31:0] pix; int h; int v; logic fs; } rec_t;
  rec_t q0[$], q1[$], q2[$], q3[$];
  int re_c0 = 0, re_c2 = 0, sr_c0 = 0, sr_c2 = 0, srco_c2 = 0;
  int pass_cnt = 0, total = 0;

  // Strobe recorder: a strobe wider than one cycle shows up as an extra entry.
  always @(negedge clk) begin
    if (v0) q0.push_back('{32'(p0), int'(h0), int'(vc0), fs0});
    if (v1) q1.push_back('{32'(p1), int'(h1), int'(vc1), fs1});
    if (v2) q2.push_back('{32'(p2), int'(h2), int'(vc2), fs2});
    if (v3) q3.push_back('{32'(p3), int'(h3), int'(vc3), fs3});
    if (re0) re_c0++;
    if (sr0) sr_c0++;
    if (re2) re_c2++;
    if (sr2) sr_c2++;
    if (sr2 && re2) srco_c2++;
  end

  // One camera sample: pclk low for 1 clk, high for 3 (pclk = clk/4).
  task automatic smp(input logic h, input logic v, input logic [7:0] d);
    @(negedge clk); pclk = 1'b0; hs = h; vs = v; data = d;
    @(negedge clk); pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; hs = 1'b0; vs = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame_begin();
    smp(1'b0, 1'b0, 8'h00);
    smp(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1; hs = 1'b1; vs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); pclk = 1'b0; data = 8'h5A;
      @(negedge clk); pclk = 1'b1;
    end
    @(negedge clk);
    total++; if (v0 !== 1'b0) $display("FAIL reset_valid got %b exp 0", v0); else pass_cnt++;
    total++; if (p0 !== 16'h0) $display("FAIL reset_pixel got %h exp 0000", p0); else pass_cnt++;
    total++; if ({h0, vc0} !== 21'h0) $display("FAIL reset_counts got h=%0d v=%0d exp 0/0", h0, vc0); else pass_cnt++;
    total++; if ({fs0, re0, sr0} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {fs0, re0, sr0}); else pass_cnt++;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (q0.size() !== 0) $display("FAIL reset_no_event got %0d strobes exp 0", q0.size()); else pass_cnt++;
    hs = 1'b0; vs = 1'b0;
  endtask

  task automatic test_pack_order();
    int b0, b1, b2, r0, s0, s2;
    do_reset(); frame_begin();
    b0 = q0.size(); b1 = q1.size(); b2 = q2.size(); r0 = re_c0; s0 = sr_c0; s2 = sr_c2;
    smp(1'b1, 1'b1, 8'hAB);
    @(negedge clk); pclk = 1'b0; data = 8'hCD;
    @(negedge clk); pclk = 1'b1;
    @(negedge clk);
    total++; if ({v0, p0} !== {1'b1, 16'hABCD}) $display("FAIL latency_first got v=%b p=%h exp v=1 p=abcd", v0, p0); else pass_cnt++;
    @(negedge clk);
    total++; if (v0 !== 1'b0) $display("FAIL strobe_width got %b exp 0", v0); else pass_cnt++;
    repeat (8) @(negedge clk);
    total++; if (q0.size() !== b0 + 1 || p0 !== 16'hABCD) $display("FAIL pclk_idle got n=%0d p=%h exp n=%0d p=abcd", q0.size(), p0, b0 + 1); else pass_cnt++;
    smp(1'b1, 1'b1, 8'h12); smp(1'b1, 1'b1, 8'h34); smp(1'b0, 1'b1, 8'h00); smp(1'b0, 1'b1, 8'h00);
    total++; if (q0.size() !== b0 + 2) $display("FAIL msb_count got %0d exp %0d", q0.size(), b0 + 2); else pass_cnt++;
    total++; if (q0[b0].pix !== 32'hABCD || q0[b0].h !== 0 || q0[b0].fs !== 1'b1) $display("FAIL msb_pix0 got %h h=%0d fs=%b exp abcd h=0 fs=1", q0[b0].pix, q0[b0].h, q0[b0].fs); else pass_cnt++;
    total++; if (q0[b0+1].pix !== 32'h1234 || q0[b0+1].h !== 1 || q0[b0+1].fs !== 1'b0) $display("FAIL msb_pix1 got %h h=%0d fs=%b exp 1234 h=1 fs=0", q0[b0+1].pix, q0[b0+1].h, q0[b0+1].fs); else pass_cnt++;
    total++; if (re_c0 - r0 !== 1 || sr_c0 - s0 !== 0) $display("FAIL msb_row_end got re=%0d sr=%0d exp 1/0", re_c0 - r0, sr_c0 - s0); else pass_cnt++;
    total++; if (q1.size() !== b1 + 2 || q1[b1].pix !== 32'hCDAB || q1[b1+1].pix !== 32'h3412) $display("FAIL lsb_pixels got n=%0d %h %h exp cdab 3412", q1.size() - b1, q1[b1].pix, q1[b1+1].pix); else pass_cnt++;
    total++; if (q2.size() !== b2 + 1 || q2[b2].pix !== 32'hABCD12 || sr_c2 - s2 !== 1) $display("FAIL bpp3_partial got n=%0d %h sr=%0d exp 1 abcd12 1", q2.size() - b2, q2[b2].pix, sr_c2 - s2); else pass_cnt++;
  endtask

  task automatic test_short_row();
    int b2, r2, s2, c2;
    do_reset(); frame_begin();
    b2 = q2.size(); r2 = re_c2; s2 = sr_c2; c2 = srco_c2;
    for (int i = 1; i <= 7; i++) smp(1'b1, 1'b1, 8'(i));
    smp(1'b0, 1'b1, 8'h00);
    total++; if (srco_c2 - c2 !== 1 || sr_c2 - s2 !== 1) $display("FAIL short_coincident got co=%0d sr=%0d exp 1/1", srco_c2 - c2, sr_c2 - s2); else pass_cnt++;
    smp(1'b1, 1'b1, 8'h0A); smp(1'b1, 1'b1, 8'h0B); smp(1'b1, 1'b1, 8'h0C); smp(1'b0, 1'b1, 8'h00);
    total++; if (q2.size() !== b2 + 3) $display("FAIL short_count got %0d exp 3", q2.size() - b2); else pass_cnt++;
    total++; if (q2[b2].pix !== 32'h010203 || q2[b2].fs !== 1'b1 || q2[b2+1].pix !== 32'h040506 || q2[b2+1].h !== 1) $display("FAIL short_line0 got %h fs=%b %h h=%0d exp 010203 1 040506 1", q2[b2].pix, q2[b2].fs, q2[b2+1].pix, q2[b2+1].h); else pass_cnt++;
    total++; if (q2[b2+2].pix !== 32'h0A0B0C || q2[b2+2].h !== 0 || q2[b2+2].v !== 1 || q2[b2+2].fs !== 1'b0) $display("FAIL short_line1 got %h h=%0d v=%0d fs=%b exp 0a0b0c 0 1 0", q2[b2+2].pix, q2[b2+2].h, q2[b2+2].v, q2[b2+2].fs); else pass_cnt++;
    total++; if (re_c2 - r2 !== 2 || sr_c2 - s2 !== 1) $display("FAIL short_totals got re=%0d sr=%0d exp 2/1", re_c2 - r2, sr_c2 - s2); else pass_cnt++;
  endtask

  task automatic test_reset_midline();
    int b0, r0, s0;
    do_reset(); frame_begin();
    smp(1'b1, 1'b1, 8'h99);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    b0 = q0.size(); r0 = re_c0; s0 = sr_c0;
    smp(1'b1, 1'b1, 8'h11); smp(1'b1, 1'b1, 8'h22); smp(1'b0, 1'b1, 8'h00);
    total++; if (q0.size() !== b0 + 1 || q0[b0].pix !== 32'h1122 || q0[b0].h !== 0) $display("FAIL midreset_pixel got n=%0d %h h=%0d exp 1 1122 0", q0.size() - b0, q0[b0].pix, q0[b0].h); else pass_cnt++;
    total++; if (sr_c0 - s0 !== 0 || re_c0 - r0 !== 1) $display("FAIL midreset_flags got sr=%0d re=%0d exp 0/1", sr_c0 - s0, re_c0 - r0); else pass_cnt++;
  endtask

  task automatic test_ignore_no_vs();
    int b0, r0;
    do_reset();
    b0 = q0.size(); r0 = re_c0;
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b0, 8'(8'h40 + i));
    smp(1'b0, 1'b0, 8'h00);
    total++; if (q0.size() !== b0 || re_c0 !== r0) $display("FAIL ignore_hs_only got n=%0d re=%0d exp 0/0", q0.size() - b0, re_c0 - r0); else pass_cnt++;
  endtask

  task automatic test_hcount_sat();
    int b3, b0;
    int exp_h[6] = '{0, 1, 2, 3, 3, 3};
    do_reset(); frame_begin();
    b3 = q3.size(); b0 = q0.size();
    for (int i = 0; i < 12; i++) smp(1'b1, 1'b1, 8'(i));
    smp(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      total++; if (q3[b3+i].h !== exp_h[i]) $display("FAIL hsat_%0d got %0d exp %0d", i, q3[b3+i].h, exp_h[i]); else pass_cnt++;
    end
    total++; if (q3.size() !== b3 + 6 || q0[b0+5].h !== 5) $display("FAIL hsat_wide got n=%0d h=%0d exp 6 5", q3.size() - b3, q0[b0+5].h); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int b0, herr, verr, perr, col, ln;
    logic [7:0] s0, s1;
    do_reset(); frame_begin();
    b0 = q0.size();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 1280; i++) smp(1'b1, 1'b1, 8'(i));
      smp(1'b0, 1'b1, 8'h00); smp(1'b0, 1'b1, 8'h00);
    end
    total++; if (vc0 !== 10'd3) $display("FAIL frame_rows got %0d exp 3", vc0); else pass_cnt++;
    smp(1'b0, 1'b0, 8'h00);
    total++; if (vc0 !== 10'd0) $display("FAIL vs_fall_rewind got %0d exp 0", vc0); else pass_cnt++;
    total++; if (q0.size() - b0 !== 1920) $display("FAIL frame_count got %0d exp 1920", q0.size() - b0); else pass_cnt++;
    herr = 0; verr = 0; perr = 0;
    for (int j = 0; j < 1920 && b0 + j < q0.size(); j++) begin
      col = j % 640; ln = j / 640;
      s0 = 8'(2 * col); s1 = 8'(2 * col + 1);
      if (q0[b0+j].h !== col) herr++;
      if (q0[b0+j].v !== ln) verr++;
      if (q0[b0+j].pix !== {16'h0, s0, s1}) perr++;
    end
    for (int l = 0; l < 3; l++) begin
      total++; if (q0[b0+640*l+639].h !== 639) $display("FAIL line%0d_last_h got %0d exp 639", l, q0[b0+640*l+639].h); else pass_cnt++;
    end
    total++; if (herr !== 0 || verr !== 0) $display("FAIL frame_positions got herr=%0d verr=%0d exp 0/0", herr, verr); else pass_cnt++;
    total++; if (perr !== 0) $display("FAIL frame_pixels got %0d bad exp 0", perr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pack_order();
    test_short_row();
    test_reset_midline();
    test_ignore_no_vs();
    test_hcount_sat();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
